// File: rtl/add8b_serial_pkg.sv
// Shared ALU definitions: serial-adder state encoding and default datapath width.
package add8b_serial_pkg;

    localparam int unsigned DATASIZE_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/add1b.sv
// 1-bit full adder cell; adder-side counterpart of the 1-bit subtractor cell.
module add1b (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic w_p;

    assign w_p = a ^ b;
    assign s   = w_p ^ ci;
    assign co  = (a & b) | (ci & w_p);

endmodule

// File: rtl/add8b_serial.sv
// Bit-serial adder: iJ + iK + iC through one full-adder cell, LSB first, with
// carry vector and 8085 flags (carry, aux carry, zero, even parity).
module add8b_serial
    import add8b_serial_pkg::*;
#(
    parameter int unsigned DATASIZE = DATASIZE_DEF,
    parameter int unsigned AUXBIT   = 3
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iStart,
    input  logic [DATASIZE-1:0] iJ,
    input  logic [DATASIZE-1:0] iK,
    input  logic                iC,
    output logic [DATASIZE-1:0] oS,
    output logic [DATASIZE-1:0] oCv,
    output logic                oC,
    output logic                oA,
    output logic                oZ,
    output logic                oP,
    output logic                oBusy,
    output logic                oDone
);

    localparam int unsigned CW = (DATASIZE > 2) ? $clog2(DATASIZE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DATASIZE - 1);

    state_e              r_state;
    state_e              w_state_next;
    logic [DATASIZE-1:0] r_j;
    logic [DATASIZE-1:0] r_k;
    logic                r_carry;
    logic [CW-1:0]       r_cnt;
    logic [DATASIZE-1:0] r_sum;
    logic [DATASIZE-1:0] r_cv;
    logic                r_c;
    logic                r_a;
    logic                r_z;
    logic                r_p;

    logic                w_accept;
    logic                w_last;
    logic                w_s;
    logic                w_co;
    logic [DATASIZE-1:0] w_sum_next;
    logic [DATASIZE-1:0] w_cv_next;

    add1b u_add1b (
        .a  (r_j[0]),
        .b  (r_k[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (iStart) begin
                    w_state_next = ST_RUN;
                    w_accept     = 1'b1;
                end
            end
            ST_RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_next = ST_DONE;
                    w_last       = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Sum enters at the MSB so the first bit computed lands in bit 0 after DATASIZE shifts.
    always_comb begin
        w_sum_next       = {w_s, r_sum[DATASIZE-1:1]};
        w_cv_next        = r_cv;
        w_cv_next[r_cnt] = w_co;
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_state <= ST_IDLE;
            r_j     <= '0;
            r_k     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cv    <= '0;
            r_c     <= 1'b0;
            r_a     <= 1'b0;
            r_z     <= 1'b0;
            r_p     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_j     <= iJ;
                r_k     <= iK;
                r_carry <= iC;
                r_cnt   <= '0;
                r_sum   <= '0;
                r_cv    <= '0;
                r_c     <= 1'b0;
                r_a     <= 1'b0;
                r_z     <= 1'b0;
                r_p     <= 1'b0;
            end else if (r_state == ST_RUN) begin
                r_j     <= r_j >> 1;
                r_k     <= r_k >> 1;
                r_carry <= w_co;
                r_cnt   <= r_cnt + CW'(1);
                r_sum   <= w_sum_next;
                r_cv    <= w_cv_next;
                // Flags land with the last sum bit so they are valid alongside oDone.
                if (w_last) begin
                    r_c <= w_co;
                    r_a <= w_cv_next[AUXBIT];
                    r_z <= ~|w_sum_next;
                    r_p <= ~^w_sum_next;
                end
            end
        end
    end

    assign oS    = r_sum;
    assign oCv   = r_cv;
    assign oC    = r_c;
    assign oA    = r_a;
    assign oZ    = r_z;
    assign oP    = r_p;
    assign oBusy = (r_state == ST_RUN);
    assign oDone = (r_state == ST_DONE);

endmodule

// File: tb/tb_add8b_serial.sv
// Self-checking bench for add8b_serial: directed plan vectors plus random operands
// against an arithmetic reference model.
module tb_add8b_serial;

    logic       iClk = 1'b0;
    logic       iRst;
    logic       iStart;
    logic [7:0] iJ;
    logic [7:0] iK;
    logic       iC;
    logic [7:0] oS;
    logic [7:0] oCv;
    logic       oC;
    logic       oA;
    logic       oZ;
    logic       oP;
    logic       oBusy;
    logic       oDone;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    add8b_serial #(
        .DATASIZE (8),
        .AUXBIT   (3)
    ) dut (
        .iClk   (iClk),
        .iRst   (iRst),
        .iStart (iStart),
        .iJ     (iJ),
        .iK     (iK),
        .iC     (iC),
        .oS     (oS),
        .oCv    (oCv),
        .oC     (oC),
        .oA     (oA),
        .oZ     (oZ),
        .oP     (oP),
        .oBusy  (oBusy),
        .oDone  (oDone)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    // Reference: plain integer addition; carry out of bit n is the overflow of the low n+1 bits.
    task automatic model(input logic [7:0] j, input logic [7:0] k, input logic c,
                         output logic [7:0] s, output logic [7:0] cv);
        int unsigned total;
        int unsigned m;
        int unsigned part;
        total = int'(j) + int'(k) + int'(c);
        s = total[7:0];
        for (int n = 0; n < 8; n++) begin
            m = (32'd1 << (n + 1)) - 1;
            part = (int'(j) & m) + (int'(k) & m) + int'(c);
            cv[n] = ((part >> (n + 1)) & 1) != 0;
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] j, input logic [7:0] k,
                                input logic c);
        logic [7:0] s;
        logic [7:0] cv;
        model(j, k, c, s, cv);
        check({tag, "_s"}, 32'(oS), 32'(s));
        check({tag, "_cv"}, 32'(oCv), 32'(cv));
        check({tag, "_c"}, 32'(oC), 32'(cv[7]));
        check({tag, "_a"}, 32'(oA), 32'(cv[3]));
        check({tag, "_z"}, 32'(oZ), 32'(s == 8'h00));
        check({tag, "_p"}, 32'(oP), 32'(($countones(s) % 2) == 0));
    endtask

    // Called one step after an edge; leaves iStart high only for the accepting edge.
    task automatic start_op(input logic [7:0] j, input logic [7:0] k, input logic c);
        iJ     = j;
        iK     = k;
        iC     = c;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        iJ     = $urandom;
        iK     = $urandom;
        iC     = $urandom;
    endtask

    // Counts busy cycles from the current one until oDone, bounded.
    task automatic wait_done(input string tag, input int exp_busy);
        int busy = 0;
        int n    = 0;
        while (!oDone && n < 40) begin
            if (oBusy) busy++;
            tick();
            n++;
        end
        check({tag, "_done"}, 32'(oDone), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'(exp_busy));
    endtask

    initial begin
        logic [7:0] rj;
        logic [7:0] rk;
        logic       rc;

        iRst   = 1'b1;
        iStart = 1'b0;
        iJ     = 8'h00;
        iK     = 8'h00;
        iC     = 1'b0;
        tick();
        tick();
        iRst = 1'b0;
        check("reset_outs", 32'({oS, oCv, oC, oA, oZ, oP, oBusy, oDone}), 32'd0);
        tick();
        check("idle_hold", 32'({oBusy, oDone}), 32'd0);

        start_op(8'h3A, 8'h2C, 1'b0);
        wait_done("tp1", 8);
        check("tp1_s_const", 32'(oS), 32'h66);
        check("tp1_flags_const", 32'({oC, oA, oZ, oP}), 32'b0101);
        check_result("tp1", 8'h3A, 8'h2C, 1'b0);
        tick();
        check("tp1_hold", 32'({oDone, oS}), 32'h166);

        start_op(8'hFF, 8'h01, 1'b0);
        check("tp2_accept_clr", 32'({oDone, oS, oCv}), 32'd0);
        wait_done("tp2", 8);
        check("tp2_cv_const", 32'(oCv), 32'hFF);
        check_result("tp2", 8'hFF, 8'h01, 1'b0);

        start_op(8'h80, 8'h80, 1'b1);
        wait_done("tp3", 8);
        check("tp3_s_const", 32'(oS), 32'h01);
        check_result("tp3", 8'h80, 8'h80, 1'b1);

        // Start pulse during RUN cycle 3 must be ignored.
        start_op(8'h12, 8'h34, 1'b0);
        tick();
        tick();
        iJ     = 8'hFF;
        iK     = 8'hFF;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        check("ign_busy", 32'(oBusy), 32'd1);
        wait_done("ign", 5);
        check("ign_s_const", 32'(oS), 32'h46);
        check_result("ign", 8'h12, 8'h34, 1'b0);

        // Reset in RUN cycle 4 discards the operation.
        start_op(8'h55, 8'h0F, 1'b1);
        tick();
        tick();
        tick();
        iRst = 1'b1;
        tick();
        iRst = 1'b0;
        check("midrst_outs", 32'({oS, oCv, oC, oA, oZ, oP, oBusy, oDone}), 32'd0);
        start_op(8'h01, 8'h01, 1'b0);
        wait_done("postrst", 8);
        check("postrst_s_const", 32'(oS), 32'h02);
        check_result("postrst", 8'h01, 8'h01, 1'b0);

        // Back-to-back: iStart held high through DONE.
        iJ     = 8'h0F;
        iK     = 8'h01;
        iC     = 1'b0;
        iStart = 1'b1;
        tick();
        check("b2b_accept", 32'({oBusy, oDone}), 32'b10);
        wait_done("b2b1", 8);
        check_result("b2b1", 8'h0F, 8'h01, 1'b0);
        tick();
        check("b2b_done_1cyc", 32'({oBusy, oDone}), 32'b10);
        iStart = 1'b0;
        wait_done("b2b2", 8);
        check("b2b2_s_const", 32'({oS, oA, oC}), 32'({8'h10, 1'b1, 1'b0}));
        check_result("b2b2", 8'h0F, 8'h01, 1'b0);

        for (int i = 0; i < 24; i++) begin
            rj = $urandom;
            rk = $urandom;
            rc = $urandom;
            start_op(rj, rk, rc);
            wait_done($sformatf("rnd%0d", i), 8);
            check_result($sformatf("rnd%0d", i), rj, rk, rc);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/add8b_serial.md
Name: add8b_serial

Overview:
- Bit-serial adder for the 8085 ALU. It is the addition-side counterpart to the ripple subtractor.
- It computes iJ + iK + iC one bit per clock through a single 1-bit full-adder cell. Operands and results are held in shift registers.
- It produces the sum, the per-bit carry vector, and the flag set that the flag unit needs: carry, auxiliary carry, zero and parity.
- It sits beside the combinational ALU path, for area-constrained builds, behind a start/done handshake.

Parameters:
- DATASIZE, 8, operand and result width in bits. Must be 2 or more.
- AUXBIT, 3, bit index whose carry-out drives oA. Must be less than DATASIZE.

Ports:
- iClk  input  1  clock; all state changes on the rising edge.
- iRst  input  1  synchronous, active-high reset.
- iStart  input  1  request. Sampled only in IDLE or DONE.
- iJ  input  DATASIZE  augend, captured on the accepting edge.
- iK  input  DATASIZE  addend, captured on the accepting edge.
- iC  input  1  carry-in, captured on the accepting edge.
- oS  output  DATASIZE  sum; valid while oDone=1.
- oCv  output  DATASIZE  per-bit carry-out vector; bit n is the carry out of bit n.
- oC  output  1  carry out of the MSB.
- oA  output  1  auxiliary carry, equal to the carry out of bit AUXBIT.
- oZ  output  1  1 when oS is all zeros.
- oP  output  1  even parity of oS, 8085 convention: 1 when the count of ones is even.
- oBusy  output  1  high in RUN.
- oDone  output  1  high in DONE.

Behaviour:
- Reset: on iRst=1 at an edge, the block enters IDLE and clears all outputs and internal registers, including the bit counter and the carry flop. This applies in any state, including mid-RUN; the operation in flight is discarded.
- States: IDLE, RUN, DONE.
  - IDLE with iStart=1 goes to RUN.
  - RUN with counter = DATASIZE-1 goes to DONE.
  - DONE with iStart=1 goes to RUN.
  - Every other case holds the current state.
- Accepting edge (IDLE or DONE with iStart=1):
  - capture iJ and iK into the operand shift registers;
  - load the carry flop with iC;
  - clear the counter to 0;
  - clear oS, oCv and all flags;
  - drop oDone.
- RUN, each edge:
  - The full-adder cell takes bit 0 of each operand register plus the carry flop.
  - The sum bit shifts into the MSB of the sum register; after DATASIZE shifts, bit 0 is the LSB result.
  - The carry-out goes to the carry flop and is written to oCv[counter].
  - Both operand registers shift right by one.
  - The counter increments.
- Latency: oBusy is high for exactly DATASIZE cycles. oDone rises on edge DATASIZE+1, counting the accepting edge as edge 1.
- Flags: oC, oA, oZ and oP are registered on the final RUN edge, together with the last sum bit, so they are valid on the same cycle as oDone.
  - oC = oCv[DATASIZE-1]
  - oA = oCv[AUXBIT]
  - oZ and oP are computed from the complete sum.
- Hold: in DONE, all results hold until the next accept or reset.
- iStart during RUN is ignored and is not queued.
- Back-to-back operation: iStart held high in DONE restarts immediately. oDone is high for one cycle, then drops on the accepting edge.
- Width: the sum wraps modulo 2^DATASIZE. The overflow is visible only as oC.
- iJ, iK and iC may change freely after the accepting edge.

Decomposition:
- Shared ALU package holds:
  - the state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - the default DATASIZE.
- One sub-module: add1b, the 1-bit full adder with inputs a, b, ci and outputs s, co. It is instantiated once; it is the adder-side counterpart of the 1-bit subtractor cell.
- The parity and zero reduction stays inline.

Test Plan:
- Start with iJ=0x3A, iK=0x2C, iC=0 -> 9 edges later oDone=1; oS=0x66, oC=0, oA=1, oZ=0, oP=1; oBusy high for exactly 8 cycles.
- Start with iJ=0xFF, iK=0x01, iC=0 -> oS=0x00, oCv=0xFF, oC=1, oA=1, oZ=1, oP=1.
- Start with iJ=0x80, iK=0x80, iC=1 -> oS=0x01, oC=1, oA=0, oZ=0, oP=0.
- Start with 0x12+0x34, then pulse iStart with 0xFF+0xFF at RUN cycle 3 -> the second request is ignored; result oS=0x46, oC=0.
- Assert iRst at RUN cycle 4 -> next cycle IDLE, every output 0. Then start 0x01+0x01 -> oS=0x02 with normal 9-edge latency.
- Hold iStart=1 through DONE with new operands 0x0F+0x01 -> oDone is high for one cycle, drops, and a second run yields oS=0x10, oA=1, oC=0.
